// File: rtl/wb_burst_reader_if.sv
// Wishbone bus bundle between one initiator and one target.
// master modport: drives the cycle/strobe/address side, samples ack/err/rty/read data.
// slave modport : the mirror image.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst reader: fetches `len` consecutive 32-bit words starting at
// start_adr using incrementing bursts and streams them out through a FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/start_adr/len command strobe, byte address, word count (0 = no-op)
//   busy, done, error   command in progress, end pulse, sticky bus error
//   dout/dout_valid/dout_ready  output stream (head of FIFO)
//   wb_m                Wishbone master port
module wb_burst_reader #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      start_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    wshb_if.master           wb_m
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t           state;
    logic             cyc_q;
    logic [31:0]      adr_q;
    logic [2:0]       cti_q;
    logic [LEN_W-1:0] rem;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             stb_c;
    logic             fail_c;
    logic             beat_c;
    logic             pop_c;
    logic [LEN_W-1:0] rem_next_c;
    logic [CW-1:0]    count_next_c;

    // Strobe only while there is guaranteed room for the returned word.
    assign stb_c      = (state == S_RUN) && (count < CW'(FIFO_DEPTH));
    assign fail_c     = stb_c & (wb_m.err | wb_m.rty);
    assign beat_c     = stb_c & wb_m.ack & ~fail_c;
    assign pop_c      = dout_valid & dout_ready;
    assign rem_next_c = rem - LEN_W'(1);

    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = stb_c;
    assign wb_m.adr    = adr_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.dat_ms = 32'h0;
    assign wb_m.cti    = cti_q;
    assign wb_m.bte    = 2'b00;

    // Command FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc_q <= 1'b0;
            adr_q <= 32'h0;
            cti_q <= 3'b000;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (len != '0) begin
                            adr_q <= start_adr & 32'hFFFF_FFFC;
                            rem   <= len;
                            cti_q <= (len == LEN_W'(1)) ? 3'b000 : 3'b010;
                            cyc_q <= 1'b1;
                            busy  <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_END;
                        end
                    end
                end
                S_RUN: begin
                    if (fail_c) begin
                        error <= 1'b1;
                        cyc_q <= 1'b0;
                        cti_q <= 3'b000;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_END;
                    end else if (beat_c) begin
                        adr_q <= adr_q + 32'd4;
                        rem   <= rem_next_c;
                        if (rem == LEN_W'(1)) begin
                            cyc_q <= 1'b0;
                            cti_q <= 3'b000;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_END;
                        end else begin
                            // Only multi-beat bursts get here; mark the last beat.
                            cti_q <= (rem_next_c == LEN_W'(1)) ? 3'b111 : 3'b010;
                        end
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next_c = count;
        if (beat_c && !pop_c) begin
            count_next_c = count + CW'(1);
        end else if (pop_c && !beat_c) begin
            count_next_c = count - CW'(1);
        end
    end

    // FIFO pointers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (beat_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next_c;
            dout_valid <= (count_next_c != '0);
        end
    end

    // FIFO storage; data words need no reset.
    always_ff @(posedge clk) begin
        if (beat_c) begin
            mem[wr_ptr] <= wb_m.dat_sm;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: memory slave model with optional
// random wait states and error injection, stream sink with optional random
// back-pressure, and a reference model built from address arithmetic.
module tb_wb_burst_reader;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 12;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [31:0]   start_adr = 32'h0;
    logic [LW-1:0] len       = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    wshb_if bus ();

    wb_burst_reader #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_adr  (start_adr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .wb_m       (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [31:0] mem [1024];
    logic        ack_en    = 1'b0;
    int          beat_no   = 0;
    int          err_beat  = -1;
    bit          wait_rand = 1'b0;
    bit          rdy_rand  = 1'b0;
    bit          rdy_fixed = 1'b1;
    logic        err_hit;

    assign err_hit    = bus.cyc & bus.stb & ack_en & (beat_no == err_beat);
    assign bus.ack    = bus.cyc & bus.stb & ack_en & ~err_hit;
    assign bus.err    = err_hit;
    assign bus.rty    = 1'b0;
    assign bus.dat_sm = mem[bus.adr[11:2]];

    // Registered-feedback slave: answers one cycle after it first sees stb.
    always @(posedge clk) begin
        ack_en <= bus.cyc & bus.stb & (wait_rand ? ($urandom_range(2, 0) != 0) : 1'b1);
        if (!bus.cyc) beat_no <= 0;
        else if (bus.ack) beat_no <= beat_no + 1;
    end

    always @(posedge clk) begin
        #1;
        dout_ready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_fixed;
    end

    // ---------------- monitor ----------------
    logic [31:0] adr_log [$];
    logic [2:0]  cti_log [$];
    logic [31:0] out_log [$];
    int          beat_cyc [$];
    int          cyc_cnt = 0, done_cnt = 0, last_beat_cyc = -1, err_cyc = -1, done_cyc = -1;
    logic        done_bus_cyc = 1'b0, done_busy = 1'b0;

    always @(negedge clk) begin
        cyc_cnt++;
        if (rst_n) begin
            if (bus.cyc & bus.stb & bus.ack) begin
                adr_log.push_back(bus.adr);
                cti_log.push_back(bus.cti);
                beat_cyc.push_back(cyc_cnt);
                last_beat_cyc = cyc_cnt;
            end
            if (bus.cyc & bus.stb & bus.err) err_cyc = cyc_cnt;
            if (dout_valid & dout_ready) out_log.push_back(dout);
            if (done) begin
                done_cnt++;
                done_cyc     = cyc_cnt;
                done_bus_cyc = bus.cyc;
                done_busy    = busy;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_adr  [$];
    logic [31:0] exp_word [$];
    logic [2:0]  exp_cti  [$];

    task automatic model(input logic [31:0] a, input int n);
        exp_adr.delete(); exp_word.delete(); exp_cti.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] x;
            x = (a & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_adr.push_back(x);
            exp_word.push_back(mem[x[11:2]]);
            exp_cti.push_back((n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010));
        end
    endtask

    task automatic clear_logs();
        adr_log.delete(); cti_log.delete(); out_log.delete(); beat_cyc.delete();
        last_beat_cyc = -1; err_cyc = -1; done_cyc = -1;
    endtask

    // Start pulse sampled at edge k; returns #1 after edge k (cycle k+1).
    task automatic issue(input logic [31:0] a, input int n);
        @(posedge clk); #1;
        start = 1'b1; start_adr = a; len = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > d0) begin ok = 1'b1; return; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!dout_valid) begin ok = 1'b1; return; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.cyc !== 1'b0)      begin bad++; $display("FAIL reset_cyc got=%b exp=0", bus.cyc); end
        total++; if (bus.stb !== 1'b0)      begin bad++; $display("FAIL reset_stb got=%b exp=0", bus.stb); end
        total++; if (bus.cti !== 3'b000)    begin bad++; $display("FAIL reset_cti got=%b exp=000", bus.cti); end
        total++; if (bus.adr !== 32'h0)     begin bad++; $display("FAIL reset_adr got=%h exp=0", bus.adr); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (error !== 1'b0)        begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
        total++; if (dout_valid !== 1'b0)   begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        total++; if (bus.we !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b exp=0", bus.we); end
        total++; if (bus.sel !== 4'hF)      begin bad++; $display("FAIL reset_sel got=%h exp=f", bus.sel); end
        total++; if (bus.bte !== 2'b00)     begin bad++; $display("FAIL reset_bte got=%b exp=00", bus.bte); end
        total++; if (bus.dat_ms !== 32'h0)  begin bad++; $display("FAIL reset_dat_ms got=%h exp=0", bus.dat_ms); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_burst4();
        bit ok; int d0;
        rdy_fixed = 1'b1; wait_rand = 1'b0; err_beat = -1;
        model(32'h100, 4); clear_logs(); d0 = done_cnt;
        issue(32'h100, 4);
        total++; if (bus.cyc !== 1'b1)   begin bad++; $display("FAIL b4_cyc_k1 got=%b exp=1", bus.cyc); end
        total++; if (bus.stb !== 1'b1)   begin bad++; $display("FAIL b4_stb_k1 got=%b exp=1", bus.stb); end
        total++; if (bus.adr !== 32'h100) begin bad++; $display("FAIL b4_adr_k1 got=%h exp=100", bus.adr); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL b4_busy got=%b exp=1", busy); end
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL b4_done_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (3) @(posedge clk); #1;
        total++; if (adr_log.size() != 4) begin bad++; $display("FAIL b4_nbeats got=%0d exp=4", adr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (adr_log[i] !== exp_adr[i]) begin bad++; $display("FAIL b4_adr[%0d] got=%h exp=%h", i, adr_log[i], exp_adr[i]); end
            total++; if (cti_log[i] !== exp_cti[i]) begin bad++; $display("FAIL b4_cti[%0d] got=%b exp=%b", i, cti_log[i], exp_cti[i]); end
            total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL b4_dout[%0d] got=%h exp=%h", i, out_log[i], exp_word[i]); end
        end
        total++; if (out_log.size() != 4) begin bad++; $display("FAIL b4_nout got=%0d exp=4", out_log.size()); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL b4_ndone got=%0d exp=1", done_cnt - d0); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL b4_error got=%b exp=0", error); end
        total++; if (done_cyc != last_beat_cyc + 1) begin bad++; $display("FAIL b4_done_timing got=%0d exp=%0d", done_cyc, last_beat_cyc + 1); end
        total++; if (done_bus_cyc !== 1'b0) begin bad++; $display("FAIL b4_cyc_at_done got=%b exp=0", done_bus_cyc); end
        total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL b4_busy_at_done got=%b exp=0", done_busy); end
        total++; if (beat_cyc.size() == 4 && beat_cyc[3] - beat_cyc[0] != 3) begin bad++; $display("FAIL b4_throughput got=%0d exp=3", beat_cyc[3] - beat_cyc[0]); end
    endtask

    task automatic test_single();
        bit ok; int d0;
        model(32'h7, 1); clear_logs(); d0 = done_cnt;
        issue(32'h7, 1);
        total++; if (bus.adr !== 32'h4) begin bad++; $display("FAIL single_adr got=%h exp=4", bus.adr); end
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (2) @(posedge clk); #1;
        total++; if (adr_log.size() != 1) begin bad++; $display("FAIL single_nbeats got=%0d exp=1", adr_log.size()); end
        total++; if (cti_log[0] !== 3'b000) begin bad++; $display("FAIL single_cti got=%b exp=000", cti_log[0]); end
        total++; if (out_log.size() != 1) begin bad++; $display("FAIL single_nout got=%0d exp=1", out_log.size()); end
        total++; if (out_log[0] !== exp_word[0]) begin bad++; $display("FAIL single_dout got=%h exp=%h", out_log[0], exp_word[0]); end
        total++; if (done_cyc != last_beat_cyc + 1) begin bad++; $display("FAIL single_done_timing got=%0d exp=%0d", done_cyc, last_beat_cyc + 1); end
    endtask

    task automatic test_backpressure();
        bit ok; int d0;
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk); #1;
        model(32'h200, 12); clear_logs(); d0 = done_cnt;
        issue(32'h200, 12);
        repeat (40) @(posedge clk); #1;
        total++; if (adr_log.size() != DEPTH) begin bad++; $display("FAIL bp_nbeats_full got=%0d exp=%0d", adr_log.size(), DEPTH); end
        total++; if (bus.cyc !== 1'b1) begin bad++; $display("FAIL bp_cyc_held got=%b exp=1", bus.cyc); end
        total++; if (bus.stb !== 1'b0) begin bad++; $display("FAIL bp_stb_wait got=%b exp=0", bus.stb); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b exp=1", busy); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_dout_valid got=%b exp=1", dout_valid); end
        rdy_fixed = 1'b1;
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (2) @(posedge clk); #1;
        total++; if (out_log.size() != 12) begin bad++; $display("FAIL bp_nout got=%0d exp=12", out_log.size()); end
        total++; if (adr_log.size() != 12) begin bad++; $display("FAIL bp_nbeats got=%0d exp=12", adr_log.size()); end
        for (int i = 0; i < 12; i++) begin
            total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL bp_dout[%0d] got=%h exp=%h", i, out_log[i], exp_word[i]); end
            total++; if (adr_log[i] !== exp_adr[i]) begin bad++; $display("FAIL bp_adr[%0d] got=%h exp=%h", i, adr_log[i], exp_adr[i]); end
        end
    endtask

    task automatic test_error();
        bit ok; int d0;
        rdy_fixed = 1'b1; err_beat = 2;
        model(32'h300, 6); clear_logs(); d0 = done_cnt;
        issue(32'h300, 6);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL err_done_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (3) @(posedge clk); #1;
        err_beat = -1;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error); end
        total++; if (out_log.size() != 2) begin bad++; $display("FAIL err_nout got=%0d exp=2", out_log.size()); end
        for (int i = 0; i < 2; i++) begin
            total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL err_dout[%0d] got=%h exp=%h", i, out_log[i], exp_word[i]); end
        end
        total++; if (done_cyc != err_cyc + 1) begin bad++; $display("FAIL err_done_timing got=%0d exp=%0d", done_cyc, err_cyc + 1); end
        total++; if (done_bus_cyc !== 1'b0) begin bad++; $display("FAIL err_cyc_at_done got=%b exp=0", done_bus_cyc); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL err_ndone got=%0d exp=1", done_cnt - d0); end
        // A fresh command clears the sticky flag.
        model(32'h400, 2); clear_logs(); d0 = done_cnt;
        issue(32'h400, 2);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", error); end
        wait_done(d0, ok);
        wait_drain(ok);
        repeat (2) @(posedge clk); #1;
        total++; if (out_log.size() != 2) begin bad++; $display("FAIL err_next_nout got=%0d exp=2", out_log.size()); end
        total++; if (out_log[1] !== exp_word[1]) begin bad++; $display("FAIL err_next_dout got=%h exp=%h", out_log[1], exp_word[1]); end
    endtask

    task automatic test_reset_mid();
        bit ok; int d0;
        rdy_fixed = 1'b1;
        clear_logs();
        issue(32'h500, 10);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (adr_log.size() >= 4) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_reach_beat5 got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.cyc !== 1'b0)    begin bad++; $display("FAIL rmid_cyc got=%b exp=0", bus.cyc); end
        total++; if (bus.stb !== 1'b0)    begin bad++; $display("FAIL rmid_stb got=%b exp=0", bus.stb); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rmid_dout_valid got=%b exp=0", dout_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model(32'h600, 3); clear_logs(); d0 = done_cnt;
        issue(32'h600, 3);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_after_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (2) @(posedge clk); #1;
        total++; if (out_log.size() != 3) begin bad++; $display("FAIL rmid_after_nout got=%0d exp=3", out_log.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL rmid_after_dout[%0d] got=%h exp=%h", i, out_log[i], exp_word[i]); end
        end
    endtask

    task automatic test_wrap_len0();
        bit ok; int d0;
        rdy_fixed = 1'b1;
        model(32'hFFFF_FFF8, 3); clear_logs(); d0 = done_cnt;
        issue(32'hFFFF_FFF8, 3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%b exp=1", busy); end
        // Start pulsed mid-command must be dropped.
        @(posedge clk); #1;
        start = 1'b1; start_adr = 32'h40; len = LW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
        wait_drain(ok);
        repeat (10) @(posedge clk); #1;
        total++; if (adr_log.size() != 3) begin bad++; $display("FAIL wrap_nbeats got=%0d exp=3", adr_log.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (adr_log[i] !== exp_adr[i]) begin bad++; $display("FAIL wrap_adr[%0d] got=%h exp=%h", i, adr_log[i], exp_adr[i]); end
            total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL wrap_dout[%0d] got=%h exp=%h", i, out_log[i], exp_word[i]); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wrap_ndone got=%0d exp=1", done_cnt - d0); end
        // Zero-length command: done next cycle, no bus activity.
        clear_logs(); d0 = done_cnt;
        issue(32'h80, 0);
        total++; if (done !== 1'b1)    begin bad++; $display("FAIL len0_done got=%b exp=1", done); end
        total++; if (bus.cyc !== 1'b0) begin bad++; $display("FAIL len0_cyc got=%b exp=0", bus.cyc); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL len0_busy got=%b exp=0", busy); end
        repeat (5) @(posedge clk); #1;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL len0_ndone got=%0d exp=1", done_cnt - d0); end
        total++; if (adr_log.size() != 0) begin bad++; $display("FAIL len0_nbeats got=%0d exp=0", adr_log.size()); end
    endtask

    task automatic test_random();
        bit ok; int d0; int n; logic [31:0] a;
        rdy_rand = 1'b1; wait_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            n = $urandom_range(20, 1);
            model(a, n); clear_logs(); d0 = done_cnt;
            issue(a, n);
            wait_done(d0, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done_timeout got=0 exp=1", it); end
            wait_drain(ok);
            repeat (2) @(posedge clk); #1;
            total++; if (out_log.size() != n) begin bad++; $display("FAIL rnd%0d_nout got=%0d exp=%0d", it, out_log.size(), n); end
            total++; if (adr_log.size() != n) begin bad++; $display("FAIL rnd%0d_nbeats got=%0d exp=%0d", it, adr_log.size(), n); end
            for (int i = 0; i < n; i++) begin
                total++; if (out_log[i] !== exp_word[i]) begin bad++; $display("FAIL rnd%0d_dout[%0d] got=%h exp=%h", it, i, out_log[i], exp_word[i]); end
                total++; if (adr_log[i] !== exp_adr[i]) begin bad++; $display("FAIL rnd%0d_adr[%0d] got=%h exp=%h", it, i, adr_log[i], exp_adr[i]); end
                total++; if (cti_log[i] !== exp_cti[i]) begin bad++; $display("FAIL rnd%0d_cti[%0d] got=%b exp=%b", it, i, cti_log[i], exp_cti[i]); end
            end
            total++; if (error !== 1'b0) begin bad++; $display("FAIL rnd%0d_error got=%b exp=0", it, error); end
        end
        rdy_rand = 1'b0; wait_rand = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_burst4();
        test_single();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_wrap_len0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
